// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with single outstanding transfer, per-grant
// timeout and registered done/error pulses back to the owning master.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  // master 0 (CPU)
  input  logic        m0_req,
  input  logic [29:0] m0_address,
  input  logic [31:0] m0_data_out,
  input  logic [3:0]  m0_data_strobes,
  input  logic        m0_write,
  // master 1 (DMA / debug)
  input  logic        m1_req,
  input  logic [29:0] m1_address,
  input  logic [31:0] m1_data_out,
  input  logic [3:0]  m1_data_strobes,
  input  logic        m1_write,
  // master responses
  output logic        m0_grant,
  output logic        m1_grant,
  output logic        m0_done,
  output logic        m1_done,
  output logic        m0_error,
  output logic        m1_error,
  output logic [31:0] read_data,
  // bus side
  output logic [29:0] address,
  output logic [31:0] data_out,
  output logic [3:0]  data_strobes,
  output logic        read,
  output logic        write,
  input  logic [31:0] data_in,
  input  logic        ack
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic [31:0]     read_data_q, read_data_d;
  logic            m0_done_q, m0_done_d;
  logic            m1_done_q, m1_done_d;
  logic            m0_error_q, m0_error_d;
  logic            m1_error_q, m1_error_d;

  // Signals of whichever master currently owns the bus
  logic            gnt_idx;
  logic            sel_req;
  logic [29:0]     sel_address;
  logic [31:0]     sel_data_out;
  logic [3:0]      sel_data_strobes;
  logic            sel_write;

  assign gnt_idx = (state_q == StGrant1);
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    if (gnt_idx) begin
      sel_req          = m1_req;
      sel_address      = m1_address;
      sel_data_out     = m1_data_out;
      sel_data_strobes = m1_data_strobes;
      sel_write        = m1_write;
    end else begin
      sel_req          = m0_req;
      sel_address      = m0_address;
      sel_data_out     = m0_data_out;
      sel_data_strobes = m0_data_strobes;
      sel_write        = m0_write;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    read_data_d  = read_data_q;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    m0_error_d   = 1'b0;
    m1_error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (m0_req && m1_req) begin
          // round-robin: the master that did not own the bus last goes first
          state_d = last_grant_q ? StGrant0 : StGrant1;
        end else if (m0_req) begin
          state_d = StGrant0;
        end else if (m1_req) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        if (ack) begin
          if (!sel_write) read_data_d = data_in;
          m0_done_d    = !gnt_idx;
          m1_done_d    = gnt_idx;
          last_grant_d = gnt_idx;
          cnt_d        = '0;
          state_d      = StIdle;
        end else if (!sel_req) begin
          last_grant_d = gnt_idx;
          cnt_d        = '0;
          state_d      = StIdle;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TimeoutVal)) begin
          m0_error_d   = !gnt_idx;
          m1_error_d   = gnt_idx;
          last_grant_d = gnt_idx;
          cnt_d        = '0;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      read_data_q  <= '0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      m0_error_q   <= 1'b0;
      m1_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      m0_done_q    <= m0_done_d;
      m1_done_q    <= m1_done_d;
      m0_error_q   <= m0_error_d;
      m1_error_q   <= m1_error_d;
    end
  end

  assign m0_grant  = (state_q == StGrant0);
  assign m1_grant  = (state_q == StGrant1);
  assign m0_done   = m0_done_q;
  assign m1_done   = m1_done_q;
  assign m0_error  = m0_error_q;
  assign m1_error  = m1_error_q;
  assign read_data = read_data_q;

  // Bus is driven straight from the owning master; quiet when idle
  always_comb begin
    address      = '0;
    data_out     = '0;
    data_strobes = '0;
    read         = 1'b0;
    write        = 1'b0;
    if (state_q == StGrant0 || state_q == StGrant1) begin
      address      = sel_address;
      data_out     = sel_data_out;
      data_strobes = sel_data_strobes;
      read         = !sel_write;
      write        = sel_write;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, read, round-robin, timeout, abort and
// reset-during-grant scenarios with hand-computed expectations.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [29:0] m0_address, m1_address;
  logic [31:0] m0_data_out, m1_data_out;
  logic [3:0]  m0_data_strobes, m1_data_strobes;
  logic        m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error;
  logic [31:0] read_data, data_out, data_in;
  logic [29:0] address;
  logic [3:0]  data_strobes;
  logic        read, write, ack;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clock          (clock),
    .reset          (reset),
    .m0_req         (m0_req),
    .m0_address     (m0_address),
    .m0_data_out    (m0_data_out),
    .m0_data_strobes(m0_data_strobes),
    .m0_write       (m0_write),
    .m1_req         (m1_req),
    .m1_address     (m1_address),
    .m1_data_out    (m1_data_out),
    .m1_data_strobes(m1_data_strobes),
    .m1_write       (m1_write),
    .m0_grant       (m0_grant),
    .m1_grant       (m1_grant),
    .m0_done        (m0_done),
    .m1_done        (m1_done),
    .m0_error       (m0_error),
    .m1_error       (m1_error),
    .read_data      (read_data),
    .address        (address),
    .data_out       (data_out),
    .data_strobes   (data_strobes),
    .read           (read),
    .write          (write),
    .data_in        (data_in),
    .ack            (ack)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_req = 0; m0_write = 0; m0_address = '0; m0_data_out = '0; m0_data_strobes = '0;
    m1_req = 0; m1_write = 0; m1_address = '0; m1_data_out = '0; m1_data_strobes = '0;
    data_in = '0; ack = 1'b0;
    #12;
    checks++;
    if ({m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error});
    end
    checks++;
    if ({read, write, address, data_out, data_strobes, read_data} !== '0) begin
      errors++;
      $display("FAIL reset_bus: rd=%b wr=%b addr=%h do=%h st=%h rdata=%h expected all 0",
               read, write, address, data_out, data_strobes, read_data);
    end
    reset = 1'b1;
  endtask

  // m0 reads byte address 0x100, slave acks on second granted cycle
  task automatic test_read();
    m0_address = 30'h40; m0_write = 1'b0; m0_data_strobes = 4'hf; m0_req = 1'b1;
    step();
    checks++;
    if ({m0_grant, m1_grant, read, write} !== 4'b1010) begin
      errors++;
      $display("FAIL read_grant: got g0 g1 rd wr=%b expected 1010", {m0_grant, m1_grant, read, write});
    end
    checks++;
    if (address !== 30'h40) begin
      errors++;
      $display("FAIL read_address: got %h expected 00000040", address);
    end
    step();
    checks++;
    if (m0_grant !== 1'b1) begin
      errors++;
      $display("FAIL read_hold: got m0_grant=%b expected 1", m0_grant);
    end
    ack = 1'b1; data_in = 32'hDEADBEEF;
    step();
    ack = 1'b0; m0_req = 1'b0; data_in = '0;
    checks++;
    if ({m0_done, m0_error, m0_grant, read} !== 4'b1000) begin
      errors++;
      $display("FAIL read_done: got done err g0 rd=%b expected 1000", {m0_done, m0_error, m0_grant, read});
    end
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_data: got %h expected deadbeef", read_data);
    end
    step();
    checks++;
    if (m0_done !== 1'b0) begin
      errors++;
      $display("FAIL read_done_pulse: got m0_done=%b expected 0", m0_done);
    end
  endtask

  // Both masters held after reset with ack held high: m0, idle, m1, idle, m0
  task automatic test_round_robin();
    logic [1:0] exp_g [5];
    exp_g[0] = 2'b01; exp_g[1] = 2'b00; exp_g[2] = 2'b10; exp_g[3] = 2'b00; exp_g[4] = 2'b01;
    apply_reset();
    m0_address = 30'h10; m0_write = 1'b0; m0_data_strobes = 4'hf;
    m1_address = 30'h20; m1_write = 1'b1; m1_data_out = 32'hA5A5A5A5; m1_data_strobes = 4'hc;
    m0_req = 1'b1; m1_req = 1'b1; ack = 1'b1; data_in = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({m1_grant, m0_grant} !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_grant_%0d: got g1g0=%b expected %b", i, {m1_grant, m0_grant}, exp_g[i]);
      end
      if (i == 1) begin
        checks++;
        if ({m0_done, m1_done, read_data} !== {2'b10, 32'hCAFEF00D}) begin
          errors++;
          $display("FAIL rr_m0_done: got d0=%b d1=%b rdata=%h expected 1 0 cafef00d",
                   m0_done, m1_done, read_data);
        end
        data_in = 32'h11111111;
      end
      if (i == 2) begin
        checks++;
        if ({write, read, data_out, data_strobes, address} !== {2'b10, 32'hA5A5A5A5, 4'hc, 30'h20}) begin
          errors++;
          $display("FAIL rr_m1_bus: got wr=%b rd=%b do=%h st=%h addr=%h expected 1 0 a5a5a5a5 c 20",
                   write, read, data_out, data_strobes, address);
        end
      end
      if (i == 3) begin
        checks++;
        if ({m0_done, m1_done, read_data} !== {2'b01, 32'hCAFEF00D}) begin
          errors++;
          $display("FAIL rr_m1_done: got d0=%b d1=%b rdata=%h expected 0 1 cafef00d",
                   m0_done, m1_done, read_data);
        end
      end
    end
    m1_req = 1'b0;
    step();
    m0_req = 1'b0; ack = 1'b0;
    checks++;
    if ({m0_done, read_data} !== {1'b1, 32'h11111111}) begin
      errors++;
      $display("FAIL rr_final: got d0=%b rdata=%h expected 1 11111111", m0_done, read_data);
    end
    step();
  endtask

  // m1 write never acked: error after exactly 15 granted cycles
  task automatic test_timeout();
    int n;
    m1_address = 30'h80; m1_write = 1'b1; m1_data_out = 32'h12345678; m1_data_strobes = 4'b0011;
    m1_req = 1'b1;
    step();
    checks++;
    if ({m1_grant, write, read, data_out, data_strobes} !== {3'b110, 32'h12345678, 4'b0011}) begin
      errors++;
      $display("FAIL to_bus: got g1=%b wr=%b rd=%b do=%h st=%b expected 1 1 0 12345678 0011",
               m1_grant, write, read, data_out, data_strobes);
    end
    n = m1_grant ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!m1_grant) break;
      n++;
    end
    m1_req = 1'b0;
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL to_cycles: got %0d granted cycles expected 15", n);
    end
    checks++;
    if ({m1_error, m1_done, m1_grant, m0_grant} !== 4'b1000) begin
      errors++;
      $display("FAIL to_error: got err done g1 g0=%b expected 1000", {m1_error, m1_done, m1_grant, m0_grant});
    end
    step();
    checks++;
    if (m1_error !== 1'b0) begin
      errors++;
      $display("FAIL to_error_pulse: got m1_error=%b expected 0", m1_error);
    end
  endtask

  // m0 drops request before ack: abort, and a later ack is ignored
  task automatic test_abort();
    m0_address = 30'h44; m0_write = 1'b0; m0_req = 1'b1;
    step();
    checks++;
    if (m0_grant !== 1'b1) begin
      errors++;
      $display("FAIL abort_grant: got m0_grant=%b expected 1", m0_grant);
    end
    m0_req = 1'b0;
    step();
    checks++;
    if ({m0_grant, m0_done, m0_error, read} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: got g0 done err rd=%b expected 0000", {m0_grant, m0_done, m0_error, read});
    end
    ack = 1'b1; data_in = 32'h22222222;
    step();
    ack = 1'b0;
    checks++;
    if ({m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error, read_data} !==
        {6'b0, 32'h11111111}) begin
      errors++;
      $display("FAIL abort_ack_ignored: got flags=%b rdata=%h expected 000000 11111111",
               {m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error}, read_data);
    end
  endtask

  // Reset during an m1 grant clears outputs at once; m0 wins contention afterwards
  task automatic test_reset_mid();
    m1_address = 30'h3ff; m1_write = 1'b1; m1_data_out = 32'hFFFF0000; m1_data_strobes = 4'hf;
    m1_req = 1'b1;
    step();
    checks++;
    if (m1_grant !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: got m1_grant=%b expected 1", m1_grant);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({m1_grant, write, address, data_out, data_strobes, read_data} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got g1=%b wr=%b addr=%h do=%h st=%h rdata=%h expected all 0",
               m1_grant, write, address, data_out, data_strobes, read_data);
    end
    m0_req = 1'b1; m0_write = 1'b0;
    #2 reset = 1'b1;
    step();
    checks++;
    if ({m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error} !== 6'b100000) begin
      errors++;
      $display("FAIL rstmid_after: got g0 g1 d0 d1 e0 e1=%b expected 100000",
               {m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
